// File: rtl/i2f_pkg.sv
// ---------------------------------------------------------------------------
// i2f_pkg
// Shared types and constants for the sequential integer-to-binary16
// converter (int2flt_seq) and its rounding stage (i2f_round).
//   - state_t            : converter FSM states
//   - BIAS_DEF, MAG_W_DEF: default exponent bias / integer magnitude width
//   - binary16 layout    : SIGN_B, EXP_MSB, EXP_LSB, EXP_W, MANT_W, FLT_W
// ---------------------------------------------------------------------------
package i2f_pkg;

    localparam int BIAS_DEF  = 15;
    localparam int MAG_W_DEF = 15;

    // binary16 field positions
    localparam int FLT_W   = 16;
    localparam int SIGN_B  = 15;
    localparam int EXP_MSB = 14;
    localparam int EXP_LSB = 10;
    localparam int EXP_W   = EXP_MSB - EXP_LSB + 1;
    localparam int MANT_W  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        NORM = 1'b1
    } state_t;

endpackage

// File: rtl/i2f_round.sv
// ---------------------------------------------------------------------------
// i2f_round
// Combinational mantissa extraction and rounding for a normalized magnitude
// (leading one in mag[MAG_W-1]). The leading one is the implicit bit and is
// dropped; the next MANT_W bits form the mantissa.
//
// Build option (macro I2F_ROUND_EN):
//   defined   : round-to-nearest-even using guard and sticky bits; a carry
//               out of the mantissa clears it and bumps the exponent.
//   undefined : truncate; guard and sticky are ignored.
//
// Ports:
//   exp      in  EXP_W   biased exponent of the leading one
//   mag      in  MAG_W   normalized magnitude
//   exp_rnd  out EXP_W   exponent after rounding
//   mant_rnd out MANT_W  mantissa after rounding
// ---------------------------------------------------------------------------
module i2f_round
    import i2f_pkg::*;
#(
    parameter int MAG_W = MAG_W_DEF
) (
    input  logic [EXP_W-1:0]  exp,
    input  logic [MAG_W-1:0]  mag,
    output logic [EXP_W-1:0]  exp_rnd,
    output logic [MANT_W-1:0] mant_rnd
);

    logic [MANT_W-1:0] mant_raw;

    assign mant_raw = mag[MAG_W-2 -: MANT_W];

`ifdef I2F_ROUND_EN

    // Round-to-nearest-even; returns {exponent, mantissa}.
    function automatic logic [EXP_W+MANT_W-1:0] round_rne(
        input logic [EXP_W-1:0]  e,
        input logic [MANT_W-1:0] m,
        input logic              guard,
        input logic              sticky
    );
        logic          inc;
        logic [MANT_W:0] sum;
        inc = guard & (sticky | m[0]);
        sum = {1'b0, m} + {{MANT_W{1'b0}}, inc};
        if (sum[MANT_W])
            return {EXP_W'(e + EXP_W'(1)), {MANT_W{1'b0}}};
        else
            return {e, sum[MANT_W-1:0]};
    endfunction

    logic guard_bit;
    logic sticky_bit;
    logic unused_lead;

    assign guard_bit   = mag[MAG_W-2-MANT_W];
    assign sticky_bit  = |mag[MAG_W-3-MANT_W:0];
    assign unused_lead = mag[MAG_W-1];

    assign {exp_rnd, mant_rnd} = round_rne(exp, mant_raw, guard_bit, sticky_bit);

`else

    logic unused_bits;

    // Leading one and the bits below the mantissa play no part when truncating.
    assign unused_bits = ^{mag[MAG_W-1], mag[MAG_W-2-MANT_W:0]};

    assign exp_rnd  = exp;
    assign mant_rnd = mant_raw;

`endif

endmodule

// File: rtl/int2flt_seq.sv
// ---------------------------------------------------------------------------
// int2flt_seq
// Sequential sign-magnitude integer to IEEE-754 binary16 converter.
// The magnitude is shifted left one bit per clock until its top bit is set,
// decrementing the exponent each step; the result is then rounded (or
// truncated) by i2f_round and registered.
//
// Build option: I2F_ROUND_EN selects round-to-nearest-even (see i2f_round);
// undefined gives truncation. Latency is the same in both builds.
//
// Ports:
//   clk      in   1        rising-edge clock
//   reset    in   1        asynchronous, active-low
//   start    in   1        conversion request, sampled only while idle
//   int_in   in   MAG_W+1  sign-magnitude operand (MSB = sign)
//   busy     out  1        high while a conversion is in progress
//   done     out  1        one-cycle pulse, flt_out valid
//   flt_out  out  16       binary16 result, held until the next start
// ---------------------------------------------------------------------------
module int2flt_seq
    import i2f_pkg::*;
#(
    parameter int BIAS  = BIAS_DEF,
    parameter int MAG_W = MAG_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [MAG_W:0]   int_in,
    output logic             busy,
    output logic             done,
    output logic [FLT_W-1:0] flt_out
);

    state_t            state;
    logic [MAG_W-1:0]  mag;
    logic              sgn;
    logic [EXP_W-1:0]  exp;
    logic [EXP_W-1:0]  exp_rnd;
    logic [MANT_W-1:0] mant_rnd;

    // Exponent of the top magnitude bit before any shifting.
    localparam logic [EXP_W-1:0] EXP_LOAD = EXP_W'(BIAS + MAG_W - 1);

    i2f_round #(
        .MAG_W (MAG_W)
    ) u_round (
        .exp      (exp),
        .mag      (mag),
        .exp_rnd  (exp_rnd),
        .mant_rnd (mant_rnd)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            mag     <= '0;
            sgn     <= 1'b0;
            exp     <= '0;
            done    <= 1'b0;
            flt_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (int_in[MAG_W-1:0] == '0) begin
                            // Zero of either sign converts to +0.
                            flt_out <= '0;
                            done    <= 1'b1;
                        end else begin
                            mag   <= int_in[MAG_W-1:0];
                            sgn   <= int_in[MAG_W];
                            exp   <= EXP_LOAD;
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (mag[MAG_W-1]) begin
                        flt_out <= {sgn, exp_rnd, mant_rnd};
                        done    <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        // Magnitude is nonzero, so the exponent stops at BIAS.
                        mag <= mag << 1;
                        exp <= exp - EXP_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int2flt_seq.sv
// ---------------------------------------------------------------------------
// tb_int2flt_seq
// Self-checking bench for int2flt_seq: directed cases, back-to-back starts,
// asynchronous reset mid-conversion, then random operands compared against
// an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_int2flt_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] int_in;
    logic        busy;
    logic        done;
    logic [15:0] flt_out;

    int n_chk;
    int n_fail;

    int2flt_seq dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .int_in  (int_in),
        .busy    (busy),
        .done    (done),
        .flt_out (flt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference: value = (-1)^s * 2^p * (1 + frac/2^p); mantissa is frac
    // scaled to 10 bits, rounded to nearest-even or truncated.
    function automatic logic [15:0] model_flt(input logic [15:0] v);
        int m, p, e, frac, sh, mant, r, half;
        m = int'(v[14:0]);
        if (m == 0) return 16'h0000;
        p = 0;
        for (int i = 0; i < 15; i++)
            if ((m >> i) & 1) p = i;
        e    = p + 15;
        frac = m - (1 << p);
        if (p >= 10) begin
            sh   = p - 10;
            mant = frac >> sh;
            r    = frac - (mant << sh);
`ifdef I2F_ROUND_EN
            if (sh > 0) begin
                half = 1 << (sh - 1);
                if (r > half || (r == half && (mant % 2) == 1)) mant++;
            end
            if (mant == 1024) begin
                mant = 0;
                e++;
            end
`else
            half = r;
`endif
        end else begin
            mant = frac << (10 - p);
        end
        return {v[15], 5'(e), 10'(mant)};
    endfunction

    // Edges from the accepting edge to the edge raising done.
    function automatic int model_lat(input logic [15:0] v);
        int p;
        if (v[14:0] == 15'd0) return 0;
        p = 0;
        for (int i = 0; i < 15; i++)
            if (v[i]) p = i;
        return 15 - p;
    endfunction

    task automatic convert(input logic [15:0] v, input logic [15:0] want, input int want_lat, input string tag);
        int edges, bcnt;
        @(negedge clk);
        start  = 1'b1;
        int_in = v;
        @(posedge clk);
        #1;
        start  = 1'b0;
        int_in = 16'($urandom);
        edges  = 0;
        bcnt   = 0;
        while (!done && edges < 40) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1;
            edges++;
            int_in = 16'($urandom);
        end
        check_eq($sformatf("%s_done", tag), done, 1);
        check_eq($sformatf("%s_lat", tag), edges, want_lat);
        check_eq($sformatf("%s_flt", tag), flt_out, want);
        check_eq($sformatf("%s_busy_end", tag), busy, 0);
        check_eq($sformatf("%s_busy_cnt", tag), bcnt, want_lat);
        @(posedge clk);
        #1;
        check_eq($sformatf("%s_pulse", tag), done, 0);
        check_eq($sformatf("%s_hold", tag), flt_out, want);
    endtask

    // Wait (bounded) for done while start stays as driven.
    task automatic wait_done(input string tag);
        int edges;
        edges = 0;
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check_eq($sformatf("%s_done", tag), done, 1);
    endtask

    initial begin
        logic [15:0] v;
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b0;
        start  = 1'b0;
        int_in = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_flt", flt_out, 16'h0000);
        @(negedge clk);
        reset = 1'b1;

        // Directed cases
        convert(16'h0001, 16'h3C00, 15, "one");
        convert(16'h8005, 16'hC500, 13, "neg5");
        convert(16'h0005, 16'h4500, 13, "pos5");
`ifdef I2F_ROUND_EN
        convert(16'h7FFF, 16'h7800, 1, "max");
        convert(16'd2051, 16'h6802, 4, "tie_odd");
`else
        convert(16'h7FFF, 16'h77FF, 1, "max");
        convert(16'd2051, 16'h6801, 4, "tie_odd");
`endif
        convert(16'd2049, 16'h6800, 4, "tie_even");
        convert(16'h8000, 16'h0000, 0, "neg_zero");
        convert(16'h0000, 16'h0000, 0, "zero");

        // Back-to-back: start held high across done cycles
        convert(16'h0003, model_flt(16'h0003), model_lat(16'h0003), "pre");
        @(negedge clk);
        start  = 1'b1;
        int_in = 16'h8000;
        @(posedge clk);
        #1;
        check_eq("b2b_z1_done", done, 1);
        check_eq("b2b_z1_flt", flt_out, 16'h0000);
        int_in = 16'h0000;
        @(posedge clk);
        #1;
        check_eq("b2b_z2_done", done, 1);
        int_in = 16'h4000;
        @(posedge clk);
        #1;
        check_eq("b2b_acc_busy", busy, 1);
        check_eq("b2b_acc_done", done, 0);
        int_in = 16'h0003;
        @(posedge clk);
        #1;
        check_eq("b2b_4000_done", done, 1);
        check_eq("b2b_4000_flt", flt_out, 16'h7400);
        // start still high: operand 3 accepted on the next edge, no gap
        int_in = 16'h0003;
        @(posedge clk);
        #1;
        check_eq("b2b_3_acc", busy, 1);
        int_in = 16'h0005;
        wait_done("b2b_3");
        check_eq("b2b_3_flt", flt_out, 16'h4200);
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("b2b_5_acc", busy, 1);
        wait_done("b2b_5");
        check_eq("b2b_5_flt", flt_out, 16'h4500);

        // Reset asserted during the NORM phase of 1
        @(negedge clk);
        start  = 1'b1;
        int_in = 16'h0001;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_flt", flt_out, 16'h0000);
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) check_eq("abort_no_done", done, 0);
        end
        @(negedge clk);
        reset = 1'b1;
        convert(16'h0001, 16'h3C00, 15, "after_rst");

        // Random operands against the reference model
        for (int i = 0; i < 150; i++) begin
            v = 16'($urandom);
            case ($urandom_range(0, 3))
                0: v[14:0] = v[14:0] >> $urandom_range(0, 14);
                1: v[14:0] = 15'(1 << $urandom_range(0, 14)) | (v[14:0] & 15'h000F);
                default: ;
            endcase
            convert(v, model_flt(v), model_lat(v), $sformatf("rnd%0d_%h", i, v));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
